// File: rtl/cache_arb_pkg.sv
// Shared definitions for the two-port cache arbiter: FSM state encoding and
// the width of the cache-ack wait counter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester wins outright; on a tie the
// requester that was not granted last wins (last=1 means m1 was granted last).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant from the request pair and the previous winner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates two level-style requesters onto a single cache port with one
// transaction outstanding, a per-transaction ack timeout and per-port read data.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32,
  parameter int BVAL_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  cache_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_sys_addr,
  input  logic [WORD_WIDTH-1:0] m0_sys_wdata,
  input  logic [BVAL_WIDTH-1:0] m0_sys_bval,
  input  logic                  m0_sys_rd,
  input  logic                  m0_sys_wr,
  output logic [WORD_WIDTH-1:0] m0_sys_rdata,
  output logic                  m0_sys_ack,
  output logic                  m0_sys_err,
  input  logic [ADDR_WIDTH-1:0] m1_sys_addr,
  input  logic [WORD_WIDTH-1:0] m1_sys_wdata,
  input  logic [BVAL_WIDTH-1:0] m1_sys_bval,
  input  logic                  m1_sys_rd,
  input  logic                  m1_sys_wr,
  output logic [WORD_WIDTH-1:0] m1_sys_rdata,
  output logic                  m1_sys_ack,
  output logic                  m1_sys_err,
  output logic [ADDR_WIDTH-1:0] cache_sys_addr,
  output logic [WORD_WIDTH-1:0] cache_sys_wdata,
  output logic [BVAL_WIDTH-1:0] cache_sys_bval,
  output logic                  cache_sys_rd,
  output logic                  cache_sys_wr,
  input  logic [WORD_WIDTH-1:0] cache_sys_rdata,
  input  logic                  cache_sys_ack
);

  // Counter value seen in the last WAIT cycle before giving up on the cache.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic                  win_q, win_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [BVAL_WIDTH-1:0] bval_q, bval_d;
  logic                  op_wr_q, op_wr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  cache_rd_q, cache_rd_d;
  logic                  cache_wr_q, cache_wr_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic                  m0_err_q, m0_err_d;
  logic                  m1_err_q, m1_err_d;
  logic [WORD_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WORD_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

  logic [1:0]            req_s;
  logic [1:0]            grant_s;
  logic                  sel_rd_s;
  logic                  sel_wr_s;
  logic                  fin_s;
  logic                  fin_err_s;
  logic [WORD_WIDTH-1:0] fin_data_s;

  assign req_s = {m1_sys_rd | m1_sys_wr, m0_sys_rd | m0_sys_wr};

  rr_arb2 u_rr_arb2 (
    .req   (req_s),
    .last  (last_q),
    .grant (grant_s)
  );

  // Next-state, latched-transaction and response computation
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bval_d     = bval_q;
    op_wr_d    = op_wr_q;
    cnt_d      = cnt_q;
    cache_rd_d = 1'b0;
    cache_wr_d = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    sel_rd_s   = grant_s[1] ? m1_sys_rd : m0_sys_rd;
    sel_wr_s   = grant_s[1] ? m1_sys_wr : m0_sys_wr;
    fin_s      = 1'b0;
    fin_err_s  = 1'b0;
    fin_data_s = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_s != 2'b00) begin
          win_d      = grant_s[1];
          addr_d     = grant_s[1] ? m1_sys_addr  : m0_sys_addr;
          wdata_d    = grant_s[1] ? m1_sys_wdata : m0_sys_wdata;
          bval_d     = grant_s[1] ? m1_sys_bval  : m0_sys_bval;
          // rd and wr together is a write
          op_wr_d    = sel_wr_s;
          cache_wr_d = sel_wr_s;
          cache_rd_d = sel_rd_s & ~sel_wr_s;
          cnt_d      = '0;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cache_sys_ack) begin
          fin_s      = 1'b1;
          fin_data_s = op_wr_q ? '0 : cache_sys_rdata;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion goes only to the requester that owns the transaction
    if (fin_s) begin
      if (win_q) begin
        m1_ack_d   = 1'b1;
        m1_err_d   = fin_err_s;
        m1_rdata_d = fin_data_s;
      end else begin
        m0_ack_d   = 1'b1;
        m0_err_d   = fin_err_s;
        m0_rdata_d = fin_data_s;
      end
    end else begin
      m0_ack_d = 1'b0;
      m1_ack_d = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge cache_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      bval_q     <= '0;
      op_wr_q    <= 1'b0;
      cnt_q      <= '0;
      cache_rd_q <= 1'b0;
      cache_wr_q <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bval_q     <= bval_d;
      op_wr_q    <= op_wr_d;
      cnt_q      <= cnt_d;
      cache_rd_q <= cache_rd_d;
      cache_wr_q <= cache_wr_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign cache_sys_addr  = addr_q;
  assign cache_sys_wdata = wdata_q;
  assign cache_sys_bval  = bval_q;
  assign cache_sys_rd    = cache_rd_q;
  assign cache_sys_wr    = cache_wr_q;
  assign m0_sys_ack      = m0_ack_q;
  assign m1_sys_ack      = m1_ack_q;
  assign m0_sys_err      = m0_err_q;
  assign m1_sys_err      = m1_err_q;
  assign m0_sys_rdata    = m0_rdata_q;
  assign m1_sys_rdata    = m1_rdata_q;

endmodule
